// File: rtl/conv2d_stream.sv
// Streaming R x R valid-mode 2D correlation over an H x W raster image.
// Kernel is loaded first, then pixels stream through R-1 line buffers into an R x R window.
//   state    | meaning
//   S_IDLE   | waiting for start_i
//   S_WLOAD  | accepting R*R kernel weights, row-major
//   S_STREAM | accepting pixels, emitting one result per covered window
//   S_DRAIN  | last pixel taken, waiting for final result to leave
module conv2d_stream #(
  parameter int R     = 3,
  parameter int H     = 32,
  parameter int W     = 32,
  parameter int DW    = 8,
  parameter int WW    = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 0,
  parameter int RELU  = 0
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic          clear_i,
  input  logic          w_valid_i,
  input  logic [WW-1:0] w_data_i,
  output logic          w_ready_o,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [OW-1:0] out_data_o,
  input  logic          out_ready_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam int NK  = R * R;
  localparam int KW  = (NK > 1) ? $clog2(NK) : 1;
  localparam int CW  = (W > 1) ? $clog2(W) : 1;
  localparam int RWD = (H > 1) ? $clog2(H) : 1;
  localparam int AW  = DW + WW + $clog2(NK);
  localparam int XW  = ((AW > OW) ? AW : OW) + 1;
  localparam int NL  = (R > 1) ? R - 1 : 1;
  localparam logic signed [XW-1:0] OMAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] OMIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WLOAD, S_STREAM, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic signed [WW-1:0] kern_q [NK];
  logic signed [DW-1:0] win_q  [R][R];
  logic signed [DW-1:0] lb_q   [NL][W];
  logic [KW-1:0]        kidx_q;
  logic [RWD-1:0]       row_q;
  logic [CW-1:0]        col_q;
  logic                 out_valid_q;
  logic [OW-1:0]        out_data_q;

  logic signed [DW-1:0]    col_v [R];
  logic signed [DW-1:0]    nwin  [R][R];
  logic signed [DW+WW-1:0] prod;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    sh;
  logic signed [XW-1:0]    shx;
  logic [OW-1:0]           res;
  logic in_rdy, accept, emit, last_w, last_px, drain_ok, zero_buf;

  assign in_rdy   = (state_q == S_STREAM) && (!out_valid_q || out_ready_i);
  assign accept   = in_rdy && in_valid_i;
  assign emit     = accept && (row_q >= RWD'(R-1)) && (col_q >= CW'(R-1));
  assign last_w   = (state_q == S_WLOAD) && w_valid_i && (kidx_q == KW'(NK-1));
  assign last_px  = accept && (row_q == RWD'(H-1)) && (col_q == CW'(W-1));
  assign drain_ok = !out_valid_q || out_ready_i;
  assign zero_buf = clear_i || last_w;

  // Window as it will look after this pixel shifts in; the result is taken from it directly.
  always_comb begin
    for (int i = 0; i < R; i++) begin
      if (i == R-1) col_v[i] = in_data_i;
      else          col_v[i] = lb_q[i][col_q];
    end
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) begin
        if (j == R-1) nwin[i][j] = col_v[i];
        else          nwin[i][j] = win_q[i][(j+1)%R];
      end
    prod = '0;
    acc  = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) begin
        prod = nwin[i][j] * kern_q[i*R+j];
        acc  = acc + AW'(prod);
      end
    sh  = acc >>> SHIFT;
    shx = XW'(sh);
    if (shx > OMAX)      res = OMAX[OW-1:0];
    else if (shx < OMIN) res = OMIN[OW-1:0];
    else                 res = shx[OW-1:0];
    if (RELU != 0 && res[OW-1]) res = '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_WLOAD;
      S_WLOAD:  if (last_w) state_d = S_STREAM;
      S_STREAM: if (last_px) state_d = S_DRAIN;
      S_DRAIN:  if (drain_ok) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (clear_i) state_d = S_IDLE;
  end

  always_comb begin
    w_ready_o   = (state_q == S_WLOAD);
    in_ready_o  = in_rdy;
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_DRAIN) && drain_ok && !clear_i;
    out_valid_o = out_valid_q;
    out_data_o  = out_data_q;
  end

  // Weights are reloaded every job, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == S_WLOAD && w_valid_i && !clear_i) kern_q[kidx_q] <= w_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      kidx_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < R; i++)
        for (int j = 0; j < R; j++) win_q[i][j] <= '0;
      for (int i = 0; i < NL; i++)
        for (int c = 0; c < W; c++) lb_q[i][c] <= '0;
    end else begin
      if (state_q == S_WLOAD && w_valid_i && !clear_i) kidx_q <= kidx_q + 1'b1;
      else if (state_q != S_WLOAD || clear_i)          kidx_q <= '0;

      if (zero_buf) begin
        row_q <= '0;
        col_q <= '0;
        for (int i = 0; i < R; i++)
          for (int j = 0; j < R; j++) win_q[i][j] <= '0;
        for (int i = 0; i < NL; i++)
          for (int c = 0; c < W; c++) lb_q[i][c] <= '0;
      end else if (accept) begin
        for (int i = 0; i < R; i++)
          for (int j = 0; j < R; j++) win_q[i][j] <= nwin[i][j];
        for (int i = 0; i < R-2; i++) lb_q[i][col_q] <= lb_q[i+1][col_q];
        if (R > 1) lb_q[NL-1][col_q] <= in_data_i;
        if (col_q == CW'(W-1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      if (clear_i) begin
        out_valid_q <= 1'b0;
      end else if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
